// File: rtl/vga_if.sv
// Pixel-timing bundle from the timing generator to the draw pipeline.
// The 'out' side drives the timing, and the 'in' side receives it.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with registered sync/blank decode,
// a frame-start pulse and a completed-frame counter. Colour is always black here.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29
) (
    input  logic        clk60MHz,
    input  logic        rst,
    input  logic        en,
    vga_if.out          out,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HLast      = 11'(HTotal - 1);
    localparam logic [10:0] VLast      = 11'(VTotal - 1);
    localparam logic [10:0] HBlnkStart = 11'(H_ACTIVE);
    localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncLast  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VBlnkStart = 11'(V_ACTIVE);
    localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSyncLast  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hblnk_d       = hblnk_q;
        vblnk_d       = vblnk_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (en) begin
            if (h_q == HLast) begin
                h_d = '0;
                if (v_q == VLast) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                end else begin
                    v_d = v_q + 11'd1;
                end
            end else begin
                h_d = h_q + 11'd1;
            end

            // Decode from the next counter values so flags line up with hcount/vcount.
            hblnk_d = (h_d >= HBlnkStart);
            hsync_d = (h_d >= HSyncStart) && (h_d <= HSyncLast);
            vblnk_d = (v_d >= VBlnkStart);
            vsync_d = (v_d >= VSyncStart) && (v_d <= VSyncLast);
        end
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign out.hcount  = h_q;
    assign out.vcount  = v_q;
    assign out.hsync   = hsync_q;
    assign out.vsync   = vsync_q;
    assign out.hblnk   = hblnk_q;
    assign out.vblnk   = vblnk_q;
    assign out.rgb     = 12'h000;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-size instance for line timing, freeze and reset, plus a tiny
// 8x8-total instance for whole-frame behaviour.
module tb_vga_timing_gen;

    logic        clk60MHz = 1'b0;
    logic        rst_b, en_b, rst_s, en_s;
    logic        fs_b, fs_s;
    logic [15:0] fc_b, fc_s;
    int          tests = 0;
    int          fails = 0;

    vga_if vif_b ();
    vga_if vif_s ();

    vga_timing_gen dut_b (
        .clk60MHz    (clk60MHz),
        .rst         (rst_b),
        .en          (en_b),
        .out         (vif_b),
        .frame_start (fs_b),
        .frame_cnt   (fc_b)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_s (
        .clk60MHz    (clk60MHz),
        .rst         (rst_s),
        .en          (en_s),
        .out         (vif_s),
        .frame_start (fs_s),
        .frame_cnt   (fc_s)
    );

    always #5 clk60MHz = ~clk60MHz;

    task automatic tick();
        @(posedge clk60MHz);
        @(negedge clk60MHz);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_b(input string tag);
        check({tag, " hcount"}, 32'(vif_b.hcount), 0);
        check({tag, " vcount"}, 32'(vif_b.vcount), 0);
        check({tag, " flags"}, {28'd0, vif_b.hsync, vif_b.vsync, vif_b.hblnk, vif_b.vblnk}, 0);
        check({tag, " rgb"}, 32'(vif_b.rgb), 0);
        check({tag, " frame_start"}, 32'(fs_b), 0);
        check({tag, " frame_cnt"}, 32'(fc_b), 0);
    endtask

    initial begin
        int hs_cnt, hb_cnt, vs_cnt, vb_cnt, fs_cnt, fs_at;

        rst_b = 1'b1; en_b = 1'b0; rst_s = 1'b1; en_s = 1'b0;
        tick();
        tick();
        check_zero_b("reset");

        // Default-size instance: one full line with a freeze just before hsync.
        rst_b = 1'b0; en_b = 1'b1;
        tick();
        check("first hcount", 32'(vif_b.hcount), 1);
        check("first vcount", 32'(vif_b.vcount), 0);
        hs_cnt = 0; hb_cnt = 0;
        for (int i = 2; i <= 1047; i++) begin
            tick();
            check("line hcount", 32'(vif_b.hcount), 32'(i));
            check("line hblnk", 32'(vif_b.hblnk), 32'(i >= 1024));
            check("line hsync", 32'(vif_b.hsync), 0);
            if (vif_b.hblnk) hb_cnt++;
        end
        en_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("freeze hcount", 32'(vif_b.hcount), 1047);
            check("freeze hsync", 32'(vif_b.hsync), 0);
            check("freeze hblnk", 32'(vif_b.hblnk), 1);
            check("freeze vcount", 32'(vif_b.vcount), 0);
        end
        en_b = 1'b1;
        tick();
        check("resume hcount", 32'(vif_b.hcount), 1048);
        check("resume hsync", 32'(vif_b.hsync), 1);
        hs_cnt++; hb_cnt++;
        for (int i = 1049; i <= 1343; i++) begin
            tick();
            check("tail hcount", 32'(vif_b.hcount), 32'(i));
            check("tail hsync", 32'(vif_b.hsync), 32'(i <= 1183));
            check("tail vblnk", 32'(vif_b.vblnk), 0);
            if (vif_b.hsync) hs_cnt++;
            if (vif_b.hblnk) hb_cnt++;
        end
        check("hsync cycles", 32'(hs_cnt), 136);
        check("hblnk cycles", 32'(hb_cnt), 320);
        tick();
        check("wrap hcount", 32'(vif_b.hcount), 0);
        check("wrap vcount", 32'(vif_b.vcount), 1);
        check("wrap hblnk", 32'(vif_b.hblnk), 0);
        check("wrap frame_start", 32'(fs_b), 0);

        // Mid-line reset with en still high.
        for (int i = 0; i < 500; i++) tick();
        check("pre-reset hcount", 32'(vif_b.hcount), 500);
        rst_b = 1'b1;
        tick();
        check_zero_b("mid reset");
        rst_b = 1'b0;
        tick();
        check("post-reset hcount", 32'(vif_b.hcount), 1);
        check("post-reset vcount", 32'(vif_b.vcount), 0);
        check("post-reset frame_start", 32'(fs_b), 0);
        check("post-reset frame_cnt", 32'(fc_b), 0);

        // Small instance: H_TOTAL = V_TOTAL = 8, vsync lines 5..6, vblnk lines 4..7.
        check("small reset frame_cnt", 32'(fc_s), 0);
        rst_s = 1'b0; en_s = 1'b1;
        vs_cnt = 0; vb_cnt = 0; hs_cnt = 0; fs_cnt = 0; fs_at = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (vif_s.vsync) vs_cnt++;
            if (vif_s.vblnk) vb_cnt++;
            if (vif_s.hsync) hs_cnt++;
            if (fs_s) begin fs_cnt++; fs_at = i; end
        end
        check("frame vsync cycles", 32'(vs_cnt), 16);
        check("frame vblnk cycles", 32'(vb_cnt), 32);
        check("frame hsync cycles", 32'(hs_cnt), 16);
        check("frame_start pulses", 32'(fs_cnt), 1);
        check("frame_start tick", 32'(fs_at), 64);
        check("frame end hcount", 32'(vif_s.hcount), 0);
        check("frame end vcount", 32'(vif_s.vcount), 0);
        check("frame_cnt 1", 32'(fc_s), 1);

        fs_cnt = 0;
        for (int i = 0; i < 192; i++) begin
            tick();
            if (fs_s) fs_cnt++;
        end
        check("three frames pulses", 32'(fs_cnt), 3);
        check("frame_cnt 4", 32'(fc_s), 4);

        // Hold exactly at the last pixel: no pulse while frozen.
        for (int i = 0; i < 63; i++) tick();
        check("last pixel hcount", 32'(vif_s.hcount), 7);
        check("last pixel vcount", 32'(vif_s.vcount), 7);
        en_s = 1'b0;
        tick();
        check("frozen wrap hcount", 32'(vif_s.hcount), 7);
        check("frozen frame_start", 32'(fs_s), 0);
        check("frozen frame_cnt", 32'(fc_s), 4);
        en_s = 1'b1;
        tick();
        check("late wrap frame_start", 32'(fs_s), 1);
        check("late wrap frame_cnt", 32'(fc_s), 5);
        check("late wrap vsync", 32'(vif_s.vsync), 0);
        tick();
        check("pulse width", 32'(fs_s), 0);

        // Mid-frame reset abandons the frame and clears the counter.
        for (int i = 0; i < 20; i++) tick();
        rst_s = 1'b1;
        tick();
        check("small reset hcount", 32'(vif_s.hcount), 0);
        check("small reset vcount", 32'(vif_s.vcount), 0);
        check("small reset frame_cnt", 32'(fc_s), 0);
        rst_s = 1'b0;
        tick();
        check("small restart hcount", 32'(vif_s.hcount), 1);
        check("small restart frame_start", 32'(fs_s), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
